ex_stage_mc: RTL and testbench

Parametrised execute stage for the 5-stage in-order core. It sits between decode (ID) and memory-access (MA) and uses a valid/allowin handshake on both sides. Over the single-cycle EX stage it adds:
- an iterative multi-cycle divider that stalls the stage through readygo;
- sub-word loads and stores with byte enables and misalignment detection;
- a full forwarding bus (dest, data, data-ready) back to ID;
- a flush input.

---
 rtl/ex_pkg.sv | 42 ++++
 rtl/ex_stage_mc_div_iter.sv | 120 ++++++++++++
 rtl/ex_stage_mc.sv | 218 +++++++++++++++++++++
 tb/tb_ex_stage_mc.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
// Contents: memory size codes, div_op bit positions, one-hot ALU op indices,
// divider FSM state type and the store byte-enable helper.
package ex_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  // div_op = {en, is_mod, is_unsigned}
  localparam int unsigned DIV_EN  = 2;
  localparam int unsigned DIV_MOD = 1;
  localparam int unsigned DIV_UNS = 0;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Byte-enable mask of 2^size bytes starting at lane lo (up to 8 lanes).
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] lo);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << lo;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ex_stage_mc_div_iter.sv
// Iterative radix-2 restoring divider working on operand magnitudes.
// Ports: clk/rst (sync, active-high); start begins a divide from IDLE;
// abort returns to IDLE from any state; ack releases DONE; is_signed/is_mod
// select the operation; a/b are dividend/divisor; busy/done report the FSM
// state; result is valid while done.
module div_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            ack,
  input  logic            is_signed,
  input  logic            is_mod,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  div_state_e state, state_nx;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, dvs, a_l, b_l;
  logic            sgn_l, mod_l;

  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] step_rem, step_quo, step_dvs, rem_nx, quo_nx;
  logic [XLEN:0]   shifted, diff;
  logic            take;
  logic            div_zero, neg_q, neg_r;
  logic [XLEN-1:0] q_fix, r_fix;

  assign abs_a = (is_signed & a[XLEN-1]) ? -a : a;
  assign abs_b = (is_signed & b[XLEN-1]) ? -b : b;

  // The first iteration is folded into the start edge (fed straight from the
  // operands), so only XLEN-1 BUSY cycles follow and the instruction sits in
  // EX for XLEN+1 cycles in total.
  always_comb begin
    step_rem = (state == DIV_IDLE) ? '0    : rem;
    step_quo = (state == DIV_IDLE) ? abs_a : quo;
    step_dvs = (state == DIV_IDLE) ? abs_b : dvs;
    shifted  = {step_rem, step_quo[XLEN-1]};
    diff     = shifted - {1'b0, step_dvs};
    take     = ~diff[XLEN];
    rem_nx   = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nx   = {step_quo[XLEN-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      DIV_IDLE: if (start && !abort) state_nx = DIV_BUSY;
      DIV_BUSY: begin
        if (abort)                        state_nx = DIV_IDLE;
        else if (cnt == CW'(XLEN - 1))    state_nx = DIV_DONE;
      end
      DIV_DONE: if (abort || ack) state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DIV_BUSY);
    done = (state == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_l   <= '0;
      b_l   <= '0;
      sgn_l <= 1'b0;
      mod_l <= 1'b0;
    end else if (state == DIV_IDLE && start && !abort) begin
      cnt   <= CW'(1);
      rem   <= rem_nx;
      quo   <= quo_nx;
      dvs   <= abs_b;
      a_l   <= a;
      b_l   <= b;
      sgn_l <= is_signed;
      mod_l <= is_mod;
    end else if (state == DIV_BUSY && !abort) begin
      cnt <= cnt + CW'(1);
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end

  // MIN / -1 falls out naturally: |MIN| / 1 = MIN, and negating MIN is MIN.
  always_comb begin
    div_zero = (b_l == '0);
    neg_q    = sgn_l & (a_l[XLEN-1] ^ b_l[XLEN-1]);
    neg_r    = sgn_l & a_l[XLEN-1];
    q_fix    = neg_q ? -quo : quo;
    r_fix    = neg_r ? -rem : rem;
    result   = '0;
    if (done) begin
      if (mod_l) result = div_zero ? a_l : r_fix;
      else       result = div_zero ? '1  : q_fix;
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with multi-cycle divide, sub-word memory access and
// forwarding. Sits between ID and MA with valid/allowin handshakes.
// Ports: clk/rst (sync, active-high); id_* instruction fields from ID;
// ma_allowin / ex_allowin / ex_valid handshake; ex_flush kills the resident
// instruction; ex_* fields to MA; ex_fwd_* forwarding bus to ID;
// data_sram_* request to the data SRAM (byte enables, lane-replicated data).
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned ALUOP_W = 12,
  localparam int unsigned NLANE   = XLEN / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               ma_allowin,
  output logic               ex_allowin,
  output logic               ex_valid,
  input  logic               ex_flush,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_src1_is_pc,
  input  logic               id_src2_is_imm,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_rj,
  input  logic [XLEN-1:0]    id_rkd,
  input  logic [4:0]         id_dest,
  input  logic               id_gr_we,
  input  logic               id_mem_en,
  input  logic               id_mem_we,
  input  logic [1:0]         id_mem_size,
  input  logic               id_mem_unsigned,
  input  logic [2:0]         id_div_op,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_result,
  output logic [4:0]         ex_dest,
  output logic               ex_gr_we,
  output logic               ex_res_from_mem,
  output logic               ex_mem_unsigned,
  output logic [1:0]         ex_mem_size,
  output logic [2:0]         ex_addr_lo,
  output logic               ex_misalign,
  output logic               ex_fwd_valid,
  output logic [4:0]         ex_fwd_dest,
  output logic [XLEN-1:0]    ex_fwd_data,
  output logic               ex_fwd_ready,
  output logic               data_sram_en,
  output logic [NLANE-1:0]   data_sram_we,
  output logic [XLEN-1:0]    data_sram_addr,
  output logic [XLEN-1:0]    data_sram_wdata
);

  localparam int unsigned LANE_BITS = $clog2(NLANE);
  localparam int unsigned SHW       = $clog2(XLEN);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("ex_stage_mc: XLEN must be 32 or 64");
  end

  logic               valid, first;
  logic [XLEN-1:0]    pc_l, imm_l, rj_l, rkd_l;
  logic [ALUOP_W-1:0] alu_op_l;
  logic               src1_is_pc_l, src2_is_imm_l;
  logic [4:0]         dest_l;
  logic               gr_we_l, mem_en_l, mem_we_l, mem_unsigned_l;
  logic [1:0]         mem_size_l;
  logic [2:0]         div_op_l;

  logic               readygo;
  logic               div_busy, div_done;
  logic [XLEN-1:0]    div_result;

  logic [XLEN-1:0]    src1, src2, alu_result, addr;
  logic [SHW-1:0]     shamt;
  logic               slt, sltu;

  logic [2:0]         mis_mask, lane_lo;
  logic               misalign_raw, mem_req;
  logic [NLANE-1:0]   lane_mask;
  int unsigned        rep;

  // Handshake and pipeline valid. Flush wins over a simultaneous latch;
  // first marks the entry cycle so a stalled memory op never re-issues.
  assign readygo    = ~div_op_l[DIV_EN] | div_done;
  assign ex_allowin = ~valid | (readygo & ma_allowin);
  assign ex_valid   = valid & readygo & ~ex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      first <= 1'b0;
    end else if (ex_allowin) begin
      valid <= id_valid & ~ex_flush;
      first <= id_valid & ~ex_flush;
    end else begin
      valid <= valid & ~ex_flush;
      first <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_l           <= '0;
      alu_op_l       <= '0;
      src1_is_pc_l   <= 1'b0;
      src2_is_imm_l  <= 1'b0;
      imm_l          <= '0;
      rj_l           <= '0;
      rkd_l          <= '0;
      dest_l         <= '0;
      gr_we_l        <= 1'b0;
      mem_en_l       <= 1'b0;
      mem_we_l       <= 1'b0;
      mem_size_l     <= '0;
      mem_unsigned_l <= 1'b0;
      div_op_l       <= '0;
    end else if (id_valid && ex_allowin) begin
      pc_l           <= id_pc;
      alu_op_l       <= id_alu_op;
      src1_is_pc_l   <= id_src1_is_pc;
      src2_is_imm_l  <= id_src2_is_imm;
      imm_l          <= id_imm;
      rj_l           <= id_rj;
      rkd_l          <= id_rkd;
      dest_l         <= id_dest;
      gr_we_l        <= id_gr_we;
      mem_en_l       <= id_mem_en;
      mem_we_l       <= id_mem_we;
      mem_size_l     <= id_mem_size;
      mem_unsigned_l <= id_mem_unsigned;
      div_op_l       <= id_div_op;
    end
  end

  // ALU: one-hot select as an AND-OR mux so an all-zero op yields zero.
  assign src1  = src1_is_pc_l  ? pc_l  : rj_l;
  assign src2  = src2_is_imm_l ? imm_l : rkd_l;
  assign shamt = src2[SHW-1:0];
  assign slt   = $signed(src1) < $signed(src2);
  assign sltu  = src1 < src2;

  always_comb begin
    alu_result = ({XLEN{alu_op_l[ALU_ADD]}}  & (src1 + src2))
               | ({XLEN{alu_op_l[ALU_SUB]}}  & (src1 - src2))
               | ({XLEN{alu_op_l[ALU_SLT]}}  & {{(XLEN-1){1'b0}}, slt})
               | ({XLEN{alu_op_l[ALU_SLTU]}} & {{(XLEN-1){1'b0}}, sltu})
               | ({XLEN{alu_op_l[ALU_AND]}}  & (src1 & src2))
               | ({XLEN{alu_op_l[ALU_NOR]}}  & ~(src1 | src2))
               | ({XLEN{alu_op_l[ALU_OR]}}   & (src1 | src2))
               | ({XLEN{alu_op_l[ALU_XOR]}}  & (src1 ^ src2))
               | ({XLEN{alu_op_l[ALU_SLL]}}  & (src1 << shamt))
               | ({XLEN{alu_op_l[ALU_SRL]}}  & (src1 >> shamt))
               | ({XLEN{alu_op_l[ALU_SRA]}}  & XLEN'($signed(src1) >>> shamt))
               | ({XLEN{alu_op_l[ALU_LUI]}}  & src2);
  end

  div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (valid & div_op_l[DIV_EN]),
    .abort    (ex_flush),
    .ack      (ma_allowin),
    .is_signed(~div_op_l[DIV_UNS]),
    .is_mod   (div_op_l[DIV_MOD]),
    .a        (rj_l),
    .b        (rkd_l),
    .busy     (div_busy),
    .done     (div_done),
    .result   (div_result)
  );

  // Memory access
  assign addr         = alu_result;
  assign mis_mask     = 3'((4'd1 << mem_size_l) - 4'd1);
  assign misalign_raw = |(addr[2:0] & mis_mask);
  assign lane_lo      = 3'(addr[LANE_BITS-1:0]);
  assign lane_mask    = NLANE'(byte_mask(mem_size_l, lane_lo));
  assign mem_req      = valid & first & mem_en_l & ~misalign_raw & ~ex_flush;

  // Replicate the low 2^size bytes of rkd across every lane.
  always_comb begin
    unique case (mem_size_l)
      MEM_SIZE_B: rep = 0;
      MEM_SIZE_H: rep = 1;
      MEM_SIZE_W: rep = 3;
      default:    rep = 7;
    endcase
    rep = rep & (NLANE - 1);
    data_sram_wdata = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      data_sram_wdata[8*i +: 8] = rkd_l[8*(i & rep) +: 8];
    end
  end

  assign data_sram_en   = mem_req;
  assign data_sram_we   = (mem_req & mem_we_l) ? lane_mask : '0;
  assign data_sram_addr = addr;

  // Outputs to MA and forwarding
  assign ex_pc           = pc_l;
  assign ex_result       = div_op_l[DIV_EN] ? div_result : alu_result;
  assign ex_dest         = dest_l;
  assign ex_gr_we        = gr_we_l;
  assign ex_res_from_mem = mem_en_l & ~mem_we_l;
  assign ex_mem_unsigned = mem_unsigned_l;
  assign ex_mem_size     = mem_size_l;
  assign ex_addr_lo      = addr[2:0];
  assign ex_misalign     = valid & mem_en_l & misalign_raw;

  assign ex_fwd_valid = valid & gr_we_l & (dest_l != 5'd0) & ~ex_flush;
  assign ex_fwd_dest  = dest_l;
  assign ex_fwd_data  = ex_result;
  assign ex_fwd_ready = valid & readygo & ~ex_res_from_mem;

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
  import ex_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, ma_allowin, ex_allowin, ex_valid, ex_flush;
  logic [31:0] id_pc, id_imm, id_rj, id_rkd;
  logic [11:0] id_alu_op;
  logic        id_src1_is_pc, id_src2_is_imm, id_gr_we, id_mem_en, id_mem_we, id_mem_unsigned;
  logic [4:0]  id_dest;
  logic [1:0]  id_mem_size;
  logic [2:0]  id_div_op;
  logic [31:0] ex_pc, ex_result, ex_fwd_data, data_sram_addr, data_sram_wdata;
  logic [4:0]  ex_dest, ex_fwd_dest;
  logic        ex_gr_we, ex_res_from_mem, ex_mem_unsigned, ex_misalign;
  logic [1:0]  ex_mem_size;
  logic [2:0]  ex_addr_lo;
  logic        ex_fwd_valid, ex_fwd_ready, data_sram_en;
  logic [3:0]  data_sram_we;

  ex_stage_mc #(.XLEN(32), .ALUOP_W(12)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ma_allowin(ma_allowin),
    .ex_allowin(ex_allowin), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_src1_is_pc(id_src1_is_pc),
    .id_src2_is_imm(id_src2_is_imm), .id_imm(id_imm), .id_rj(id_rj), .id_rkd(id_rkd),
    .id_dest(id_dest), .id_gr_we(id_gr_we), .id_mem_en(id_mem_en), .id_mem_we(id_mem_we),
    .id_mem_size(id_mem_size), .id_mem_unsigned(id_mem_unsigned), .id_div_op(id_div_op),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_dest(ex_dest), .ex_gr_we(ex_gr_we),
    .ex_res_from_mem(ex_res_from_mem), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_mem_size(ex_mem_size), .ex_addr_lo(ex_addr_lo), .ex_misalign(ex_misalign),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_dest(ex_fwd_dest), .ex_fwd_data(ex_fwd_data),
    .ex_fwd_ready(ex_fwd_ready), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id;
    id_valid = 1'b0; id_pc = 32'h100; id_alu_op = '0; id_src1_is_pc = 1'b0;
    id_src2_is_imm = 1'b0; id_imm = '0; id_rj = '0; id_rkd = '0; id_dest = '0;
    id_gr_we = 1'b0; id_mem_en = 1'b0; id_mem_we = 1'b0; id_mem_size = '0;
    id_mem_unsigned = 1'b0; id_div_op = '0;
  endtask

  typedef struct {
    string       name;
    int          op;
    logic        s2imm;
    logic [31:0] rj, imm, rkd;
    logic [4:0]  dest;
    logic        gr_we, mem_en, mem_we;
    logic [1:0]  size;
    logic [31:0] res;
    logic        mis, en;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        fv, fr;
  } vec_t;

  vec_t vecs[14];

  task automatic drive_vec(input vec_t v);
    clear_id();
    id_alu_op = 12'd1 << v.op; id_src2_is_imm = v.s2imm;
    id_rj = v.rj; id_imm = v.imm; id_rkd = v.rkd; id_dest = v.dest; id_gr_we = v.gr_we;
    id_mem_en = v.mem_en; id_mem_we = v.mem_we; id_mem_size = v.size;
    id_valid = 1'b1;
  endtask

  task automatic run_div(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int  low;
    bit  seen;
    clear_id();
    id_alu_op = 12'd1 << ALU_ADD; id_rj = a; id_rkd = b; id_dest = 5'd9;
    id_gr_we = 1'b1; id_div_op = op; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    low = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (ex_valid) seen = 1'b1;
      else begin
        low++;
        tick();
      end
    end
    chk({name, "_done"}, seen, 1'b1);
    chk({name, "_low_cycles"}, low, 32);
    chk({name, "_result"}, ex_result, exp);
    chk({name, "_fwd_ready"}, ex_fwd_ready, 1'b1);
    tick();
    clear_id();
  endtask

  initial begin
    int pulses;

    //      name     op        imm rj           imm          rkd          dst gw me mw sz  res          mis en we       wdata        fv fr
    vecs[0]  = '{"add",   ALU_ADD,  1, 32'd5,       32'd3,       32'd0,       3, 1, 0, 0, 0, 32'd8,       0, 0, 4'b0000, 32'h0,       1, 1};
    vecs[1]  = '{"ld_w",  ALU_ADD,  1, 32'h1000,    32'd4,       32'd0,       4, 1, 1, 0, 2, 32'h1004,    0, 1, 4'b0000, 32'h0,       1, 0};
    vecs[2]  = '{"st_b",  ALU_ADD,  1, 32'h1000,    32'd3,       32'hAABBCCDD,0, 0, 1, 1, 0, 32'h1003,    0, 1, 4'b1000, 32'hDDDDDDDD,0, 1};
    vecs[3]  = '{"st_h_mis",ALU_ADD,1, 32'h1000,    32'd1,       32'h11223344,0, 0, 1, 1, 1, 32'h1001,    1, 0, 4'b0000, 32'h0,       0, 1};
    vecs[4]  = '{"st_h",  ALU_ADD,  1, 32'h1000,    32'd2,       32'h12345678,0, 0, 1, 1, 1, 32'h1002,    0, 1, 4'b1100, 32'h56785678,0, 1};
    vecs[5]  = '{"st_w",  ALU_ADD,  1, 32'h1000,    32'd0,       32'hCAFEF00D,0, 0, 1, 1, 2, 32'h1000,    0, 1, 4'b1111, 32'hCAFEF00D,0, 1};
    vecs[6]  = '{"sub",   ALU_SUB,  0, 32'd3,       32'd0,       32'd5,       7, 1, 0, 0, 0, 32'hFFFFFFFE,0, 0, 4'b0000, 32'h0,       1, 1};
    vecs[7]  = '{"slt",   ALU_SLT,  0, 32'hFFFFFFFF,32'd0,       32'd1,       7, 1, 0, 0, 0, 32'd1,       0, 0, 4'b0000, 32'h0,       1, 1};
    vecs[8]  = '{"sltu",  ALU_SLTU, 0, 32'hFFFFFFFF,32'd0,       32'd1,       7, 1, 0, 0, 0, 32'd0,       0, 0, 4'b0000, 32'h0,       1, 1};
    vecs[9]  = '{"sra",   ALU_SRA,  0, 32'h80000000,32'd0,       32'd4,       7, 1, 0, 0, 0, 32'hF8000000,0, 0, 4'b0000, 32'h0,       1, 1};
    vecs[10] = '{"ld_w_mis",ALU_ADD,1, 32'h1000,    32'd2,       32'd0,       5, 1, 1, 0, 2, 32'h1002,    1, 0, 4'b0000, 32'h0,       1, 0};
    vecs[11] = '{"ld_b_r0",ALU_ADD, 1, 32'h1000,    32'd3,       32'd0,       0, 1, 1, 0, 0, 32'h1003,    0, 1, 4'b0000, 32'h0,       0, 0};
    vecs[12] = '{"lui",   ALU_LUI,  1, 32'd0,       32'h12345000,32'd0,       8, 1, 0, 0, 0, 32'h12345000,0, 0, 4'b0000, 32'h0,       1, 1};
    vecs[13] = '{"nor",   ALU_NOR,  0, 32'hF0F0F0F0,32'd0,       32'h0F0F0000,8, 1, 0, 0, 0, 32'h00000F0F,0, 0, 4'b0000, 32'h0,       1, 1};

    clear_id();
    rst = 1'b1; ma_allowin = 1'b1; ex_flush = 1'b0;
    repeat (3) tick();
    chk("rst_allowin", ex_allowin, 1'b1);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_sram_en", data_sram_en, 1'b0);
    chk("rst_result", ex_result, 32'h0);
    chk("rst_fwd_valid", ex_fwd_valid, 1'b0);
    chk("rst_fwd_ready", ex_fwd_ready, 1'b0);
    chk("rst_misalign", ex_misalign, 1'b0);
    rst = 1'b0;
    tick();

    // Single-cycle instructions, back to back
    for (int i = 0; i < 14; i++) begin
      drive_vec(vecs[i]);
      tick();
      id_valid = 1'b0;
      chk({vecs[i].name, "_valid"}, ex_valid, 1'b1);
      chk({vecs[i].name, "_result"}, ex_result, vecs[i].res);
      chk({vecs[i].name, "_fwd_data"}, ex_fwd_data, vecs[i].res);
      chk({vecs[i].name, "_misalign"}, ex_misalign, vecs[i].mis);
      chk({vecs[i].name, "_sram_en"}, data_sram_en, vecs[i].en);
      chk({vecs[i].name, "_sram_we"}, data_sram_we, vecs[i].we);
      chk({vecs[i].name, "_fwd_valid"}, ex_fwd_valid, vecs[i].fv);
      chk({vecs[i].name, "_fwd_ready"}, ex_fwd_ready, vecs[i].fr);
      if (vecs[i].en && vecs[i].mem_we) begin
        chk({vecs[i].name, "_wdata"}, data_sram_wdata, vecs[i].wdata);
        chk({vecs[i].name, "_addr_lo"}, ex_addr_lo, vecs[i].res[2:0]);
      end
    end
    tick();
    chk("idle_valid", ex_valid, 1'b0);

    // Divides
    run_div("div_100_7", 3'b100, 32'd100, 32'd7, 32'd14);
    run_div("div_m100_7", 3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2);
    run_div("mod_m100_7", 3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);
    run_div("div_by0", 3'b100, 32'h1234, 32'd0, 32'hFFFFFFFF);
    run_div("mod_by0", 3'b110, 32'h1234, 32'd0, 32'h1234);
    run_div("div_min_m1", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_div("mod_min_m1", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_div("divu", 3'b101, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF);

    // Store held by an MA stall issues exactly once
    ma_allowin = 1'b0;
    drive_vec(vecs[2]);
    tick();
    id_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      if (data_sram_en) pulses++;
      chk("stall_allowin", ex_allowin, 1'b0);
      chk("stall_valid", ex_valid, 1'b1);
      if (c < 2) tick();
    end
    ma_allowin = 1'b1;
    #1;
    chk("stall_release_allowin", ex_allowin, 1'b1);
    tick();
    if (data_sram_en) pulses++;
    chk("stall_en_pulses", pulses, 1);
    chk("stall_after_valid", ex_valid, 1'b0);

    // Flush mid-divide
    clear_id();
    id_alu_op = 12'd1 << ALU_ADD; id_rj = 32'd100; id_rkd = 32'd7; id_dest = 5'd9;
    id_gr_we = 1'b1; id_div_op = 3'b100; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    repeat (9) tick();
    ex_flush = 1'b1;
    #1;
    chk("flush_div_valid", ex_valid, 1'b0);
    chk("flush_div_fwd_valid", ex_fwd_valid, 1'b0);
    tick();
    ex_flush = 1'b0;
    #1;
    chk("flush_div_after_valid", ex_valid, 1'b0);
    chk("flush_div_after_allowin", ex_allowin, 1'b1);
    chk("flush_div_after_fwd", ex_fwd_valid, 1'b0);

    // Flush in the entry cycle of a load, with a new instruction offered
    drive_vec(vecs[1]);
    tick();
    ex_flush = 1'b1;
    drive_vec(vecs[0]);
    #1;
    chk("flush_ld_sram_en", data_sram_en, 1'b0);
    chk("flush_ld_fwd_valid", ex_fwd_valid, 1'b0);
    chk("flush_ld_valid", ex_valid, 1'b0);
    tick();
    ex_flush = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("flush_priority_valid", ex_valid, 1'b0);

    // Pipeline recovers: 1-cycle add, then a full-length divide
    drive_vec(vecs[0]);
    tick();
    id_valid = 1'b0;
    chk("post_flush_add_valid", ex_valid, 1'b1);
    chk("post_flush_add_result", ex_result, 32'd8);
    tick();
    run_div("post_flush_div", 3'b100, 32'd100, 32'd7, 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
